// File: rtl/bus_regfile.sv
// Register stage downstream of the shifter. It captures the bus result into
// the general-purpose registers and the CF/ZF flags, and loads the A/B operand latches.
module bus_regfile #(
  parameter int unsigned DW   = 8,
  parameter int unsigned NREG = 4,
  parameter int unsigned AW   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] bus_in,
  input  logic          we,
  input  logic [AW-1:0] wsel,
  input  logic          cf_in,
  input  logic          flag_we,
  input  logic [AW-1:0] rs_a,
  input  logic [AW-1:0] rs_b,
  input  logic          lda,
  input  logic          ldb,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic          cf,
  output logic          zf,
  output logic [DW-1:0] rd_dbg
);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic          cf_q, cf_d;
  logic          zf_q, zf_d;

  // Latch loads read regs_q, so a same-edge write is seen only on the next load.
  always_comb begin
    regs_d = regs_q;
    a_d    = a_q;
    b_d    = b_q;
    cf_d   = cf_q;
    zf_d   = zf_q;
    if (we) begin
      regs_d[wsel] = bus_in;
    end
    if (flag_we) begin
      cf_d = cf_in;
      zf_d = (bus_in == '0);
    end
    if (lda) begin
      a_d = regs_q[rs_a];
    end
    if (ldb) begin
      b_d = regs_q[rs_b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      a_q  <= '0;
      b_q  <= '0;
      cf_q <= 1'b0;
      zf_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      a_q    <= a_d;
      b_q    <= b_d;
      cf_q   <= cf_d;
      zf_q   <= zf_d;
    end
  end

  assign a_out  = a_q;
  assign b_out  = b_q;
  assign cf     = cf_q;
  assign zf     = zf_q;
  assign rd_dbg = regs_q[rs_a];

endmodule

// File: tb/tb_bus_regfile.sv
// Self-checking bench for bus_regfile: a behavioural model is compared against the DUT on every
// falling edge, and directed vectors are pinned with hand-computed literals.
`timescale 1ns/1ps
module tb_bus_regfile;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bus_in;
  logic       we;
  logic [1:0] wsel;
  logic       cf_in;
  logic       flag_we;
  logic [1:0] rs_a;
  logic [1:0] rs_b;
  logic       lda;
  logic       ldb;
  logic [7:0] a_out;
  logic [7:0] b_out;
  logic       cf;
  logic       zf;
  logic [7:0] rd_dbg;

  int checks = 0;
  int errors = 0;
  bit run    = 1'b0;

  bus_regfile #(.DW(8), .NREG(4), .AW(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_in (bus_in),
    .we     (we),
    .wsel   (wsel),
    .cf_in  (cf_in),
    .flag_we(flag_we),
    .rs_a   (rs_a),
    .rs_b   (rs_b),
    .lda    (lda),
    .ldb    (ldb),
    .a_out  (a_out),
    .b_out  (b_out),
    .cf     (cf),
    .zf     (zf),
    .rd_dbg (rd_dbg)
  );

  always #5 clk = ~clk;

  // Behavioural model: the register file is an array, the flags and latches are plain variables.
  logic [7:0] m_regs [4];
  logic [7:0] m_a, m_b;
  logic       m_cf, m_zf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_regs[i] <= 8'h00;
      m_a  <= 8'h00;
      m_b  <= 8'h00;
      m_cf <= 1'b0;
      m_zf <= 1'b0;
    end else begin
      if (we) m_regs[wsel] <= bus_in;
      if (flag_we) begin
        m_cf <= cf_in;
        m_zf <= (bus_in == 8'h00);
      end
      if (lda) m_a <= m_regs[rs_a];
      if (ldb) m_b <= m_regs[rs_b];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("cyc_a_out", 32'(a_out), 32'(m_a));
      chk("cyc_b_out", 32'(b_out), 32'(m_b));
      chk("cyc_cf", 32'(cf), 32'(m_cf));
      chk("cyc_zf", 32'(zf), 32'(m_zf));
      chk("cyc_rd_dbg", 32'(rd_dbg), 32'(m_regs[rs_a]));
    end
  end

  // Apply one cycle of controls, then sit 2ns after the active edge.
  task automatic step(input logic w, input logic [1:0] ws, input logic [7:0] d,
                      input logic fw, input logic c, input logic [1:0] ra,
                      input logic [1:0] rb, input logic la, input logic lb);
    we = w; wsel = ws; bus_in = d; flag_we = fw; cf_in = c;
    rs_a = ra; rs_b = rb; lda = la; ldb = lb;
    @(posedge clk);
    #2;
  endtask

  task automatic check_regs(input string name, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    for (int i = 0; i < 4; i++) begin
      rs_a = 2'(i);
      #0.2;
      chk(name, 32'(rd_dbg), 32'(exp[i]));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    we = 0; wsel = 0; bus_in = 0; flag_we = 0; cf_in = 0;
    rs_a = 0; rs_b = 0; lda = 0; ldb = 0;
    #1;
    run = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk("reset_a", 32'(a_out), 32'h00);
    chk("reset_b", 32'(b_out), 32'h00);
    chk("reset_flags", 32'({cf, zf}), 32'h0);

    // Write and readback.
    step(1, 2'd2, 8'hA5, 0, 0, 2'd2, 2'd0, 0, 0);
    chk("wr_rd_dbg", 32'(rd_dbg), 32'hA5);
    chk("wr_a_not_loaded", 32'(a_out), 32'h00);
    step(0, 2'd0, 8'h00, 0, 0, 2'd2, 2'd0, 1, 0);
    chk("ld_a_A5", 32'(a_out), 32'hA5);
    chk("model_a_A5", 32'(m_a), 32'hA5);

    // Flags.
    step(0, 2'd0, 8'h00, 1, 1, 2'd0, 2'd0, 0, 0);
    chk("flag_zero_cf", 32'(cf), 32'h1);
    chk("flag_zero_zf", 32'(zf), 32'h1);
    chk("model_zf", 32'(m_zf), 32'h1);
    step(0, 2'd0, 8'h80, 1, 0, 2'd0, 2'd0, 0, 0);
    chk("flag_80_cf", 32'(cf), 32'h0);
    chk("flag_80_zf", 32'(zf), 32'h0);
    step(0, 2'd0, 8'h00, 0, 1, 2'd0, 2'd0, 0, 0);
    chk("flag_hold", 32'({cf, zf}), 32'h0);

    // No write-through bypass.
    step(1, 2'd1, 8'h11, 0, 0, 2'd0, 2'd0, 0, 0);
    step(1, 2'd1, 8'h22, 0, 0, 2'd1, 2'd0, 1, 0);
    chk("nobypass_old", 32'(a_out), 32'h11);
    step(0, 2'd0, 8'h00, 0, 0, 2'd1, 2'd0, 1, 0);
    chk("nobypass_new", 32'(a_out), 32'h22);

    // Dual load, then both latches from the same register.
    step(1, 2'd0, 8'h3C, 0, 0, 2'd0, 2'd0, 0, 0);
    step(1, 2'd3, 8'hC3, 0, 0, 2'd0, 2'd0, 0, 0);
    step(0, 2'd0, 8'h00, 0, 0, 2'd0, 2'd3, 1, 1);
    chk("dual_a", 32'(a_out), 32'h3C);
    chk("dual_b", 32'(b_out), 32'hC3);
    chk("model_b_C3", 32'(m_b), 32'hC3);
    step(0, 2'd0, 8'h00, 0, 0, 2'd3, 2'd3, 1, 1);
    chk("same_a", 32'(a_out), 32'hC3);
    chk("same_b", 32'(b_out), 32'hC3);

    // Hold with random bus activity and no enables.
    for (int i = 0; i < 10; i++) begin
      step(0, 2'($urandom_range(3)), 8'($urandom), 0, 1'($urandom), 2'(i % 4),
           2'($urandom_range(3)), 0, 0);
    end
    chk("hold_a", 32'(a_out), 32'hC3);
    chk("hold_b", 32'(b_out), 32'hC3);
    chk("hold_flags", 32'({cf, zf}), 32'h0);
    check_regs("hold_regs", 8'h3C, 8'h22, 8'hA5, 8'hC3);

    // Set flags nonzero, then assert reset mid-cycle mid-write.
    step(0, 2'd0, 8'h00, 1, 1, 2'd0, 2'd0, 0, 0);
    we = 1; wsel = 2'd1; bus_in = 8'h77; lda = 1; ldb = 1; flag_we = 1; cf_in = 1;
    #1;
    rst_n = 1'b0;
    #0.5;
    chk("rst_async_a", 32'(a_out), 32'h00);
    chk("rst_async_b", 32'(b_out), 32'h00);
    chk("rst_async_cf", 32'(cf), 32'h0);
    chk("rst_async_zf", 32'(zf), 32'h0);
    check_regs("rst_async_regs", 8'h00, 8'h00, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    chk("rst_ignores_we", 32'(rd_dbg), 32'h00);
    chk("rst_ignores_ld", 32'(a_out), 32'h00);
    rst_n = 1'b1;

    // First edge after release behaves normally.
    step(1, 2'd1, 8'h5A, 0, 0, 2'd1, 2'd0, 0, 0);
    chk("post_rst_wr", 32'(rd_dbg), 32'h5A);
    step(0, 2'd0, 8'h00, 0, 0, 2'd1, 2'd1, 1, 1);
    chk("post_rst_ld", 32'({a_out, b_out}), 32'h5A5A);

    @(negedge clk);
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
